// File: rtl/alu_pkg.sv
`default_nettype none
// alu_pkg: ALU op codes and divider state shared by the pipeline controller and execute units.
// Rev 1.0
package alu_pkg;

  localparam int ALUCONTROL_WIDTH = 6;
  localparam int ALU_FLAGS_WIDTH  = 4;

  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_UDIV = 6'b101110;
  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_SDIV = 6'b101111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/execute_divider_div_step.sv
`default_nettype none
// div_step: one combinational restoring-division step on an unsigned {rem, quo} pair.
// Rev 1.0
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor always holds, so the trial fits in WIDTH+1 bits with bit WIDTH as its sign.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/execute_divider.sv
`default_nettype none
// execute_divider: iterative UDIV/SDIV unit that stalls the pipeline while a division runs.
// Rev 1.0
module execute_divider #(
  parameter int WIDTH            = 32,
  parameter int ALUCONTROL_WIDTH = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ValidE,
  input  logic [ALUCONTROL_WIDTH-1:0] ALUControlE,
  input  logic [WIDTH-1:0]            SrcAE,
  input  logic [WIDTH-1:0]            SrcBE,
  input  logic                        KillE,
  output logic                        StallDivE,
  output logic                        DivDoneE,
  output logic [WIDTH-1:0]            QuotientE,
  output logic [WIDTH-1:0]            RemainderE,
  output logic                        DivByZeroE
);

  import alu_pkg::*;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             signed_q, signed_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             w_is_udiv, w_is_sdiv, w_start, w_div_zero;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic [WIDTH-1:0] w_step_rem, w_step_quo;
  logic [WIDTH-1:0] w_fix_q, w_fix_r;

  assign w_is_udiv  = (ALUControlE == ALUCONTROL_WIDTH'(ALU_UDIV));
  assign w_is_sdiv  = (ALUControlE == ALUCONTROL_WIDTH'(ALU_SDIV));
  assign w_start    = ValidE & (w_is_udiv | w_is_sdiv) & ~KillE;
  assign w_div_zero = (SrcBE == '0);
  assign w_abs_a    = (w_is_sdiv & SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
  assign w_abs_b    = (w_is_sdiv & SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvsr_q),
    .rem_next (w_step_rem),
    .quo_next (w_step_quo)
  );

  // Fix-up works on the final step's output so results land on the edge entering DONE.
  assign w_fix_q = (signed_q & (sign_a_q ^ sign_b_q)) ? -w_step_quo : w_step_quo;
  assign w_fix_r = (signed_q & sign_a_q) ? -w_step_rem : w_step_rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= DIV_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      signed_q    <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      signed_q    <= signed_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE, DIV_DONE: begin
        if (w_start) state_d = w_div_zero ? DIV_DONE : DIV_RUN;
        else         state_d = DIV_IDLE;
      end
      DIV_RUN: begin
        if (KillE)                  state_d = DIV_IDLE;
        else if (count_q == C_LAST) state_d = DIV_DONE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_comb begin
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    signed_d    = signed_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    if (state_q != DIV_RUN) begin
      if (w_start) begin
        count_d  = '0;
        rem_d    = '0;
        quo_d    = w_abs_a;
        dvsr_d   = w_abs_b;
        signed_d = w_is_sdiv;
        sign_a_d = SrcAE[WIDTH-1];
        sign_b_d = SrcBE[WIDTH-1];
        if (w_div_zero) begin
          quotient_d  = '0;
          remainder_d = SrcAE;
          dbz_d       = 1'b1;
        end
      end
    end else if (!KillE) begin
      count_d = count_q + CW'(1);
      rem_d   = w_step_rem;
      quo_d   = w_step_quo;
      if (count_q == C_LAST) begin
        quotient_d  = w_fix_q;
        remainder_d = w_fix_r;
        dbz_d       = 1'b0;
      end
    end
  end

  always_comb begin
    DivDoneE   = (state_q == DIV_DONE);
    StallDivE  = ((state_q == DIV_IDLE) & w_start) | (state_q == DIV_RUN);
    QuotientE  = quotient_q;
    RemainderE = remainder_q;
    DivByZeroE = dbz_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_divider.sv
`default_nettype none
// tb_execute_divider: directed vectors with hand-computed results for execute_divider.
// Rev 1.0
module tb_execute_divider;

  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ValidE = 1'b0;
  logic        KillE = 1'b0;
  logic [5:0]  ALUControlE = '0;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  logic        StallDivE, DivDoneE, DivByZeroE;
  logic [31:0] QuotientE, RemainderE;

  int errors = 0;
  int checks = 0;
  int lat, stalls, seen;

  execute_divider #(.WIDTH(32), .ALUCONTROL_WIDTH(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .ValidE      (ValidE),
    .ALUControlE (ALUControlE),
    .SrcAE       (SrcAE),
    .SrcBE       (SrcBE),
    .KillE       (KillE),
    .StallDivE   (StallDivE),
    .DivDoneE    (DivDoneE),
    .QuotientE   (QuotientE),
    .RemainderE  (RemainderE),
    .DivByZeroE  (DivByZeroE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge: the start is live for the rest of this cycle.
  task automatic launch(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    ValidE      = 1'b1;
    ALUControlE = op;
    SrcAE       = a;
    SrcBE       = b;
  endtask

  task automatic wait_done(output int l, output int s);
    @(negedge clk);
    ValidE = 1'b0;
    l = 1;
    s = 0;
    while (!DivDoneE && l < 100) begin
      if (StallDivE) s++;
      @(negedge clk);
      l++;
    end
  endtask

  task automatic run_div(input string tag, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input logic edbz, input int elat);
    launch(op, a, b);
    #1 check({tag, "_stall0"}, StallDivE, 1);
    wait_done(lat, stalls);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_stalls"}, stalls, elat - 1);
    check({tag, "_q"}, QuotientE, eq);
    check({tag, "_r"}, RemainderE, er);
    check({tag, "_dbz"}, DivByZeroE, edbz);
    check({tag, "_stall_done"}, StallDivE, 0);
    @(negedge clk);
    check({tag, "_pulse"}, DivDoneE, 0);
  endtask

  initial begin
    @(negedge clk);
    check("rst_q", QuotientE, 0);
    check("rst_r", RemainderE, 0);
    check("rst_dbz", DivByZeroE, 0);
    check("rst_done", DivDoneE, 0);
    check("rst_stall", StallDivE, 0);
    reset = 1'b1;
    @(negedge clk);

    run_div("udiv_100_7", ALU_UDIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    run_div("sdiv_m7_2", ALU_SDIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run_div("sdiv_min_m1", ALU_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
    run_div("udiv_5_0", ALU_UDIV, 32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 1);

    // Kill in cycle 10 of RUN: results from the divide-by-zero must survive.
    launch(ALU_UDIV, 32'd100, 32'd7);
    @(negedge clk);
    ValidE = 1'b0;
    repeat (9) @(negedge clk);
    KillE = 1'b1;
    @(negedge clk);
    KillE = 1'b0;
    check("kill_stall", StallDivE, 0);
    check("kill_done", DivDoneE, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (DivDoneE) seen++;
    end
    check("kill_no_done", seen, 0);
    check("kill_q_hold", QuotientE, 0);
    check("kill_r_hold", RemainderE, 5);
    check("kill_dbz_hold", DivByZeroE, 1);
    run_div("udiv_9_3", ALU_UDIV, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

    // Back-to-back: second start presented during the first DONE cycle.
    launch(ALU_UDIV, 32'hFFFF_FFFF, 32'd16);
    #1 check("b2b1_stall0", StallDivE, 1);
    wait_done(lat, stalls);
    check("b2b1_lat", lat, 33);
    check("b2b1_q", QuotientE, 32'h0FFF_FFFF);
    check("b2b1_r", RemainderE, 32'd15);
    launch(ALU_SDIV, 32'd20, 32'hFFFF_FFFA);
    #1 check("b2b_done_stall", StallDivE, 0);
    check("b2b_done_pulse", DivDoneE, 1);
    wait_done(lat, stalls);
    check("b2b2_lat", lat, 33);
    check("b2b2_stalls", stalls, 32);
    check("b2b2_q", QuotientE, 32'hFFFF_FFFD);
    check("b2b2_r", RemainderE, 32'd2);
    check("b2b2_dbz", DivByZeroE, 0);
    @(negedge clk);

    // Reset asserted in cycle 15 of RUN clears outputs without waiting for an edge.
    launch(ALU_UDIV, 32'd100, 32'd7);
    @(negedge clk);
    ValidE = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mrst_q", QuotientE, 0);
    check("mrst_r", RemainderE, 0);
    check("mrst_dbz", DivByZeroE, 0);
    check("mrst_done", DivDoneE, 0);
    check("mrst_stall", StallDivE, 0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (DivDoneE || StallDivE) seen++;
    end
    check("mrst_quiet", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
